serial_frame_receiver: RTL and testbench

//  Receive end of the switch-driven serial message link: samples a 1-bit serial line,

---
 rtl/serial_frame_receiver.sv | 173 +++++++++++++++++
 tb/tb_serial_frame_receiver.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_receiver.sv
// Receiver for the switch-driven serial message link: start/payload/stop framing, MSB first.
// Optional even-parity check enabled by defining PARITY_CHECK_EN (adds par_err).
module serial_frame_receiver #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PAYLOAD_W    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sin,
    input  logic       en,
    output logic [7:0] data,
    output logic [1:0] chan,
    output logic       valid,
    output logic       busy,
`ifdef PARITY_CHECK_EN
    output logic       par_err,
`endif
    output logic       frame_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(PAYLOAD_W + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(PAYLOAD_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [PAYLOAD_W-1:0]   shreg;
    logic                   sync1;
    logic                   sin_s;
    logic                   sin_prev;
    logic                   frame_ok_c;

    // Two-flop synchroniser plus one history flop for falling-edge detection (idle-high preset)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= 1'b1;
            sin_s    <= 1'b1;
            sin_prev <= 1'b1;
        end else begin
            sync1    <= sin;
            sin_s    <= sync1;
            sin_prev <= sin_s;
        end
    end

`ifdef PARITY_CHECK_EN
    logic par_bit;
    logic par_ok_c;

    assign par_ok_c   = ~^{shreg, par_bit};
    assign frame_ok_c = sin_s & par_ok_c;
`else
    assign frame_ok_c = sin_s;
`endif

    // Frame FSM; cnt wraps to 0 at every sample point so samples stay mid-bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            data      <= '0;
            chan      <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_bit   <= 1'b0;
            par_err   <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            if (!en) begin
                state <= S_IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (sin_prev && !sin_s) begin
                            state   <= S_START;
                            cnt     <= '0;
                            bit_cnt <= '0;
                            busy    <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (cnt == CNT_HALF) begin
                            cnt <= '0;
                            if (!sin_s) begin
                                state <= S_DATA;
                            end else begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (cnt == CNT_LAST) begin
                            cnt     <= '0;
                            shreg   <= {shreg[PAYLOAD_W-2:0], sin_s};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == BITS_LAST) begin
`ifdef PARITY_CHECK_EN
                                state <= S_PARITY;
`else
                                state <= S_STOP;
`endif
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`ifdef PARITY_CHECK_EN
                    S_PARITY: begin
                        if (cnt == CNT_LAST) begin
                            cnt     <= '0;
                            par_bit <= sin_s;
                            state   <= S_STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`endif
                    S_STOP: begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            if (frame_ok_c) begin
                                data      <= shreg[7:0];
                                chan      <= shreg[9:8];
                                valid     <= 1'b1;
                                frame_err <= 1'b0;
`ifdef PARITY_CHECK_EN
                                par_err   <= 1'b0;
`endif
                            end else begin
                                frame_err <= 1'b1;
`ifdef PARITY_CHECK_EN
                                par_err   <= par_err | ~par_ok_c;
`endif
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed self-checking bench for serial_frame_receiver at CLKS_PER_BIT=4.
module tb_serial_frame_receiver;

    localparam int unsigned CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       sin;
    logic       en;
    logic [7:0] data;
    logic [1:0] chan;
    logic       valid;
    logic       busy;
    logic       frame_err;
`ifdef PARITY_CHECK_EN
    logic       par_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int valid_cnt = 0;
    int busy_cnt  = 0;
    int v0;
    int b0;

    serial_frame_receiver #(
        .CLKS_PER_BIT(CPB),
        .PAYLOAD_W   (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sin      (sin),
        .en       (en),
        .data     (data),
        .chan     (chan),
        .valid    (valid),
        .busy     (busy),
`ifdef PARITY_CHECK_EN
        .par_err  (par_err),
`endif
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Count cycles with valid/busy high, sampled on the falling edge
    always @(negedge clk) begin
        if (valid) valid_cnt <= valid_cnt + 1;
        if (busy)  busy_cnt  <= busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sin = bits[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [9:0] payload, input logic stop_b);
`ifdef PARITY_CHECK_EN
        send_bits(16'({1'b0, payload, ^payload, stop_b}), 13);
`else
        send_bits(16'({1'b0, payload, stop_b}), 12);
`endif
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b1;
        sin = 1'b1;

        // Reset held with the line toggling
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            sin = ~sin;
        end
        #1;
        check("rst_data",  32'(data), 32'h0);
        check("rst_chan",  32'(chan), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_ferr",  32'(frame_err), 32'h0);
        check("rst_busy_never", 32'(busy_cnt), 32'h0);
        @(negedge clk);
        sin = 1'b1;
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Single good frame
        v0 = valid_cnt;
        send_frame(10'b1000110101, 1'b1);
        repeat (6) @(negedge clk);
        check("good_chan",  32'(chan), 32'h2);
        check("good_data",  32'(data), 32'h35);
        check("good_valid", 32'(valid_cnt - v0), 32'd1);
        check("good_ferr",  32'(frame_err), 32'h0);
        check("good_busy",  32'(busy), 32'h0);

        // Back-to-back frames with no idle gap
        v0 = valid_cnt;
        send_frame(10'b1000110101, 1'b1);
        send_frame(10'b1001101101, 1'b1);
        repeat (6) @(negedge clk);
        check("b2b_valid", 32'(valid_cnt - v0), 32'd2);
        check("b2b_chan",  32'(chan), 32'h2);
        check("b2b_data",  32'(data), 32'h6D);

        // Bad stop bit, line held low afterwards
        send_frame(10'b1000110101, 1'b1);
        repeat (4) @(negedge clk);
        v0 = valid_cnt;
        send_frame(10'b0111111111, 1'b0);
        repeat (8) @(negedge clk);
        check("bad_ferr",  32'(frame_err), 32'h1);
        check("bad_data",  32'(data), 32'h35);
        check("bad_chan",  32'(chan), 32'h2);
        check("bad_valid", 32'(valid_cnt - v0), 32'd0);
        check("low_busy",  32'(busy), 32'h0);
        sin = 1'b1;
        repeat (4) @(negedge clk);
        v0 = valid_cnt;
        send_frame(10'b1000110101, 1'b1);
        repeat (6) @(negedge clk);
        check("clr_ferr",  32'(frame_err), 32'h0);
        check("clr_valid", 32'(valid_cnt - v0), 32'd1);

        // Two-cycle glitch on idle line
        v0 = valid_cnt;
        b0 = busy_cnt;
        sin = 1'b0;
        repeat (2) @(negedge clk);
        sin = 1'b1;
        repeat (8) @(negedge clk);
        check("glitch_busy_cycles", 32'(busy_cnt - b0), 32'd2);
        check("glitch_busy", 32'(busy), 32'h0);
        check("glitch_valid", 32'(valid_cnt - v0), 32'd0);
        check("glitch_ferr", 32'(frame_err), 32'h0);
        check("glitch_data", 32'(data), 32'h35);

        // Enable dropped mid-frame
        sin = 1'b0;
        repeat (CPB) @(negedge clk);
        sin = 1'b1;
        repeat (6) @(negedge clk);
        check("en_busy_before", 32'(busy), 32'h1);
        en = 1'b0;
        repeat (2) @(negedge clk);
        check("en_busy_after", 32'(busy), 32'h0);
        check("en_data_hold",  32'(data), 32'h35);
        repeat (40) @(negedge clk);
        en = 1'b1;
        repeat (4) @(negedge clk);

        // Reset asserted mid-DATA
        sin = 1'b0;
        repeat (CPB) @(negedge clk);
        sin = 1'b1;
        repeat (8) @(negedge clk);
        check("mid_busy", 32'(busy), 32'h1);
        rst = 1'b0;
        #1;
        check("mid_rst_data", 32'(data), 32'h0);
        check("mid_rst_chan", 32'(chan), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_ferr", 32'(frame_err), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

`ifdef PARITY_CHECK_EN
        // Payload has five ones: parity 0 is wrong, parity 1 is right
        v0 = valid_cnt;
        send_bits(16'({1'b0, 10'b1000110101, 1'b0, 1'b1}), 13);
        repeat (6) @(negedge clk);
        check("par_bad_perr",  32'(par_err), 32'h1);
        check("par_bad_ferr",  32'(frame_err), 32'h1);
        check("par_bad_valid", 32'(valid_cnt - v0), 32'd0);
        v0 = valid_cnt;
        send_bits(16'({1'b0, 10'b1000110101, 1'b1, 1'b1}), 13);
        repeat (6) @(negedge clk);
        check("par_ok_valid", 32'(valid_cnt - v0), 32'd1);
        check("par_ok_data",  32'(data), 32'h35);
        check("par_ok_perr",  32'(par_err), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
